row_assembler: RTL and testbench

- Upstream stage of the VGA output path: packs a byte stream (camera/SRAM reader) into a 480-bit row image for the row-chunk output stage.
- Presents the completed row on storage_bytes and holds finished until the consumer acknowledges.
- Double-buffered: a fill buffer plus an output holding register, so capture of row N+1 overlaps drain of row N.

---
 rtl/row_assembler.sv | 140 ++++++++++++++
 tb/tb_row_assembler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/row_assembler.sv
// row_assembler
//   Packs a byte stream into a ROW_BITS-wide row image. One fill buffer
//   captures row N+1 while the output holding register presents row N to
//   the consumer until it acknowledges.
//
//   Optional build macro: ROW_ASSEMBLER_SHORT_ROW_CNT_EN adds the short_rows
//   counter of partial rows discarded by sof.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   in_data        stream byte
//   in_valid       in_data valid
//   in_ready       block accepts in_data this cycle
//   sof            start of frame, qualified by in_valid & in_ready
//   storage_bytes  completed row, byte k at [IN_W*k +: IN_W]
//   finished       storage_bytes holds an unconsumed row
//   row_index      row number of the row on storage_bytes
//   row_ack        consumer done with the current row
//   frame_done     one-cycle pulse when the last row of a frame is loaded
//   short_rows     (macro only) saturating count of discarded partial rows
//
// Fill states
//   state   | meaning
//   FILLING | byte_cnt < BPR, accepting bytes
//   FULL    | byte_cnt == BPR, waiting for the output slot

module row_assembler #(
    parameter int ROW_BITS       = 480,
    parameter int IN_W           = 8,
    parameter int ROWS_PER_FRAME = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                sof,
    output logic [ROW_BITS-1:0] storage_bytes,
    output logic                finished,
    output logic [9:0]          row_index,
    input  logic                row_ack,
    output logic                frame_done
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
    ,
    output logic [7:0]          short_rows
`endif
);

    localparam int BPR   = ROW_BITS / IN_W;
    localparam int CNT_W = $clog2(BPR + 1);
    localparam logic [CNT_W-1:0] BPR_CNT  = CNT_W'(BPR);
    localparam logic [9:0]       LAST_ROW = 10'(ROWS_PER_FRAME - 1);

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_t;

    fill_state_t         fill_state;
    logic [ROW_BITS-1:0] fill;
    logic [CNT_W-1:0]    byte_cnt;
    logic [CNT_W-1:0]    wr_idx;
    logic [9:0]          fill_row;
    logic [9:0]          fill_row_next;
    logic                accept;
    logic                slot_free;
    logic                xfer;

    // Fill state is a pure decode of byte_cnt so the two can never disagree.
    always_comb begin
        fill_state    = (byte_cnt == BPR_CNT) ? FULL : FILLING;
        in_ready      = (fill_state == FILLING);
        accept        = in_valid & in_ready;
        // An ack in the same cycle frees the slot, so the next row can land
        // on the very edge the consumer releases the current one.
        slot_free     = ~finished | row_ack;
        xfer          = (fill_state == FULL) & slot_free;
        wr_idx        = sof ? '0 : byte_cnt;
        fill_row_next = (fill_row == LAST_ROW) ? 10'd0 : fill_row + 10'd1;
    end

    // Constant-index byte lanes keep the write decode simple and lint-clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (accept) begin
            for (int k = 0; k < BPR; k++) begin
                if (wr_idx == CNT_W'(k)) begin
                    fill[k*IN_W +: IN_W] <= in_data;
                end
            end
        end
    end

    // accept and xfer are mutually exclusive: accept needs FILLING, xfer FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt      <= '0;
            fill_row      <= '0;
            storage_bytes <= '0;
            finished      <= 1'b0;
            row_index     <= '0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (xfer) begin
                storage_bytes <= fill;
                row_index     <= fill_row;
                finished      <= 1'b1;
                byte_cnt      <= '0;
                fill_row      <= fill_row_next;
                frame_done    <= (fill_row == LAST_ROW);
            end else begin
                if (finished && row_ack) begin
                    finished <= 1'b0;
                end
                if (accept) begin
                    if (sof) begin
                        byte_cnt <= CNT_W'(1);
                        fill_row <= '0;
                    end else begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short_rows <= '0;
        end else if (accept && sof && (byte_cnt != '0) && (short_rows != 8'hFF)) begin
            short_rows <= short_rows + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_row_assembler.sv
module tb_row_assembler;

    localparam int RB = 480;

    typedef struct {
        logic [RB-1:0] data;
        logic [9:0]    idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sof = 1'b0;
    logic [RB-1:0] storage_bytes;
    logic          finished;
    logic [9:0]    row_index;
    logic          row_ack = 1'b0;
    logic          frame_done;
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
    logic [7:0]    short_rows;
`endif

    int   total = 0;
    int   bad = 0;
    int   fd_cnt = 0;
    logic [9:0] fd_row = '0;
    exp_t q[$];

    logic [RB-1:0] r0, r1, r2, r3, rr, r6;

    row_assembler #(.ROW_BITS(RB), .IN_W(8), .ROWS_PER_FRAME(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sof           (sof),
        .storage_bytes (storage_bytes),
        .finished      (finished),
        .row_index     (row_index),
        .row_ack       (row_ack),
        .frame_done    (frame_done)
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
        ,
        .short_rows    (short_rows)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_cnt = fd_cnt + 1;
            fd_row = row_index;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RB-1:0] mk_row(input int seed, input int step);
        logic [RB-1:0] r;
        r = '0;
        for (int i = 0; i < RB/8; i++) r[8*i +: 8] = 8'(seed + step*i);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic s);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("in_ready_timeout", RB'(in_ready), RB'(1));
        in_valid = 1'b1;
        in_data  = d;
        sof      = s;
        @(posedge clk);
    endtask

    task automatic send_row(input logic [RB-1:0] d, input logic [9:0] idx, input logic use_sof);
        exp_t e;
        e.data = d;
        e.idx  = idx;
        q.push_back(e);
        for (int i = 0; i < RB/8; i++) send_byte(d[8*i +: 8], use_sof && (i == 0));
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=empty_queue expected=pending_row", tag);
        end else begin
            total--;
            e = q.pop_front();
            chk({tag, "_data"}, storage_bytes, e.data);
            chk({tag, "_idx"}, RB'(row_index), RB'(e.idx));
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    initial begin
        r0 = mk_row(0, 1);
        r1 = mk_row(8'hA5, 0);
        r2 = mk_row(16, 1);
        r3 = mk_row(7, 3);
        r6 = mk_row(200, 5);

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", RB'(in_ready), RB'(1));
        chk("rst_finished", RB'(finished), RB'(0));
        chk("rst_row_index", RB'(row_index), RB'(0));
        chk("rst_storage", storage_bytes, '0);
        chk("rst_frame_done", RB'(frame_done), RB'(0));
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
        chk("rst_short_rows", RB'(short_rows), RB'(0));
`endif
        rst = 1'b0;

        // first row, output slot free
        send_row(r0, 10'd0, 1'b0);
        end_stream();
        chk("t1_full_in_ready", RB'(in_ready), RB'(0));
        chk("t1_not_yet_finished", RB'(finished), RB'(0));
        @(negedge clk);
        chk("t1_finished", RB'(finished), RB'(1));
        chk("t1_in_ready_back", RB'(in_ready), RB'(1));
        chk("t1_byte0", RB'(storage_bytes[7:0]), RB'(8'h00));
        chk("t1_byte59", RB'(storage_bytes[479:472]), RB'(8'h3B));
        pop_check("t1_row");

        // second row while first unacked, then ack loads it on the same edge
        send_row(r1, 10'd1, 1'b0);
        end_stream();
        chk("t2_stall_in_ready", RB'(in_ready), RB'(0));
        repeat (3) @(negedge clk);
        chk("t2_still_stalled", RB'(in_ready), RB'(0));
        chk("t2_hold_finished", RB'(finished), RB'(1));
        chk("t2_storage_held", storage_bytes, r0);
        chk("t2_index_held", RB'(row_index), RB'(0));
        row_ack = 1'b1;
        @(negedge clk);
        row_ack = 1'b0;
        chk("t2_finished_kept", RB'(finished), RB'(1));
        chk("t2_in_ready", RB'(in_ready), RB'(1));
        pop_check("t2_row");

        // plain ack with partial fill; ack while idle is ignored
        for (int i = 0; i < 10; i++) send_byte(r2[8*i +: 8], 1'b0);
        end_stream();
        row_ack = 1'b1;
        @(negedge clk);
        row_ack = 1'b0;
        chk("t3_ack_clears", RB'(finished), RB'(0));
        row_ack = 1'b1;
        @(negedge clk);
        row_ack = 1'b0;
        chk("t3_idle_ack_finished", RB'(finished), RB'(0));
        chk("t3_idle_ack_index", RB'(row_index), RB'(1));
        chk("t3_idle_ack_storage", storage_bytes, r1);

        // sof after 25 bytes discards the partial row
        for (int i = 10; i < 25; i++) send_byte(r2[8*i +: 8], 1'b0);
        send_row(r3, 10'd0, 1'b1);
        end_stream();
        @(negedge clk);
        chk("t4_finished", RB'(finished), RB'(1));
        chk("t4_first_byte", RB'(storage_bytes[7:0]), RB'(8'h07));
        chk("t4_frame_done", RB'(frame_done), RB'(0));
        pop_check("t4_row");
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
        chk("t4_short_rows", RB'(short_rows), RB'(1));
`endif

        // five rows with prompt acks across the frame wrap
        row_ack = 1'b1;
        @(negedge clk);
        row_ack = 1'b0;
        chk("t5_pre_ack", RB'(finished), RB'(0));
        fd_cnt = 0;
        for (int r = 0; r < 5; r++) begin
            rr = mk_row(r*17 + 3, r + 1);
            send_row(rr, 10'(r % 4), (r == 0));
            end_stream();
            @(negedge clk);
            pop_check($sformatf("t5_row%0d", r));
            chk($sformatf("t5_frame_done%0d", r), RB'(frame_done), RB'((r % 4) == 3));
            if (r < 4) begin
                row_ack = 1'b1;
                @(negedge clk);
                row_ack = 1'b0;
            end
        end
        @(negedge clk);
        chk("t5_fd_count", RB'(fd_cnt), RB'(1));
        chk("t5_fd_row", RB'(fd_row), RB'(3));
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
        chk("t5_short_rows", RB'(short_rows), RB'(1));
`endif

        // asynchronous reset mid-hold and mid-row
        for (int i = 0; i < 30; i++) send_byte(8'(i + 90), 1'b0);
        end_stream();
        chk("t6_pre_finished", RB'(finished), RB'(1));
        #2 rst = 1'b1;
        #1;
        chk("t6_async_finished", RB'(finished), RB'(0));
        chk("t6_async_index", RB'(row_index), RB'(0));
        chk("t6_async_storage", storage_bytes, '0);
        chk("t6_async_in_ready", RB'(in_ready), RB'(1));
`ifdef ROW_ASSEMBLER_SHORT_ROW_CNT_EN
        chk("t6_async_short_rows", RB'(short_rows), RB'(0));
`endif
        #1 rst = 1'b0;
        send_row(r6, 10'd0, 1'b0);
        end_stream();
        @(negedge clk);
        chk("t6_finished", RB'(finished), RB'(1));
        pop_check("t6_row");
        chk("queue_empty", RB'(q.size()), RB'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
